// File: rtl/ysyx_23060187_pkg.sv
// Shared types and constants for the NPC write-back path.
package ysyx_23060187_pkg;

    typedef enum logic [1:0] {
        WBU_IDLE      = 2'd0,
        WBU_MEM_WAIT  = 2'd1,
        WBU_REG_WRITE = 2'd2,
        WBU_DONE      = 2'd3
    } wbu_state_e;

    localparam int unsigned REG_IDX_W = 5;

    // x0 is hardwired to zero, so writes to it are dropped.
    function automatic logic reg_write_en(input logic wen, input logic [REG_IDX_W-1:0] idx);
        return wen && (idx != '0);
    endfunction

endpackage

// File: rtl/ysyx_23060187_timeout_cnt.sv
// Cycle counter that flags the increment which reaches Limit.
module ysyx_23060187_timeout_cnt #(
    parameter int unsigned Limit = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int unsigned CntW = $clog2(Limit + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High on the cycle whose increment brings the count to Limit.
    assign hit_o = en_i && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/ysyx_23060187_wbu.sv
// Write-back unit: optional store with bounded ack wait, rd commit, retire handshake to IFU.
module ysyx_23060187_wbu
    import ysyx_23060187_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exu_wbu_valid_i,
    output logic        wbu_exu_ready_o,
    input  logic        exu_wbu_register_wen_i,
    input  logic [31:0] exu_wbu_register_waddr_i,
    input  logic [31:0] exu_wbu_register_wdata_i,
    input  logic        exu_wbu_memory_wen_i,
    input  logic [31:0] exu_wbu_memory_waddr_i,
    input  logic [31:0] exu_wbu_memory_wdata_i,
    input  logic [3:0]  exu_wbu_memory_wmask_i,
    output logic        wbu_mem_req_o,
    output logic [31:0] wbu_mem_addr_o,
    output logic [31:0] wbu_mem_wdata_o,
    output logic [3:0]  wbu_mem_wmask_o,
    input  logic        mem_wbu_ack_i,
    output logic        wbu_reg_wen_o,
    output logic [4:0]  wbu_reg_waddr_o,
    output logic [31:0] wbu_reg_wdata_o,
    output logic        wbu_ifu_valid_o,
    input  logic        ifu_wbu_ready_i,
    output logic        wbu_error_o,
    output logic [31:0] wbu_retire_cnt_o
);
    wbu_state_e           state_q, state_d;
    logic                 reg_wen_q;
    logic [REG_IDX_W-1:0] reg_waddr_q;
    logic [31:0]          reg_wdata_q;
    logic [31:0]          mem_addr_q, mem_wdata_q;
    logic [3:0]           mem_wmask_q;
    logic                 error_q, error_d;
    logic [31:0]          retire_q, retire_d;
    logic                 accept, in_mem_wait, timeout_hit, retire;
    logic                 unused_waddr_hi;

    assign unused_waddr_hi = ^exu_wbu_register_waddr_i[31:REG_IDX_W];

    assign accept      = (state_q == WBU_IDLE) && exu_wbu_valid_i;
    assign in_mem_wait = (state_q == WBU_MEM_WAIT);
    assign retire      = (state_q == WBU_DONE) && ifu_wbu_ready_i;

    ysyx_23060187_timeout_cnt #(
        .Limit (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!in_mem_wait),
        .en_i   (in_mem_wait && !mem_wbu_ack_i),
        .hit_o  (timeout_hit)
    );

    always_comb begin
        state_d  = state_q;
        error_d  = error_q;
        retire_d = retire_q;
        unique case (state_q)
            WBU_IDLE: begin
                if (exu_wbu_valid_i) begin
                    state_d = exu_wbu_memory_wen_i ? WBU_MEM_WAIT : WBU_REG_WRITE;
                end
            end
            WBU_MEM_WAIT: begin
                // An ack on the limit cycle takes priority over the timeout.
                if (mem_wbu_ack_i) begin
                    state_d = WBU_REG_WRITE;
                end else if (timeout_hit) begin
                    state_d = WBU_DONE;
                    error_d = 1'b1;
                end
            end
            WBU_REG_WRITE: state_d = WBU_DONE;
            WBU_DONE: begin
                if (retire) begin
                    state_d  = WBU_IDLE;
                    retire_d = retire_q + 32'd1;
                end
            end
            default: state_d = WBU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WBU_IDLE;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            error_q     <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            retire_q <= retire_d;
            if (accept) begin
                reg_wen_q   <= exu_wbu_register_wen_i;
                reg_waddr_q <= exu_wbu_register_waddr_i[REG_IDX_W-1:0];
                reg_wdata_q <= exu_wbu_register_wdata_i;
                mem_addr_q  <= exu_wbu_memory_waddr_i;
                mem_wdata_q <= exu_wbu_memory_wdata_i;
                mem_wmask_q <= exu_wbu_memory_wmask_i;
            end
        end
    end

    assign wbu_exu_ready_o  = (state_q == WBU_IDLE);
    assign wbu_mem_req_o    = in_mem_wait;
    assign wbu_mem_addr_o   = mem_addr_q;
    assign wbu_mem_wdata_o  = mem_wdata_q;
    assign wbu_mem_wmask_o  = mem_wmask_q;
    assign wbu_reg_wen_o    = (state_q == WBU_REG_WRITE) && reg_write_en(reg_wen_q, reg_waddr_q);
    assign wbu_reg_waddr_o  = reg_waddr_q;
    assign wbu_reg_wdata_o  = reg_wdata_q;
    assign wbu_ifu_valid_o  = (state_q == WBU_DONE);
    assign wbu_error_o      = error_q;
    assign wbu_retire_cnt_o = retire_q;

endmodule

// File: tb/tb_ysyx_23060187_wbu.sv
// Randomized transaction-level bench for the write-back unit.
module tb_ysyx_23060187_wbu;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, reg_wen_in, mem_wen_in, ack, ifu_ready;
    logic [31:0] reg_waddr_in, reg_wdata_in, mem_waddr_in, mem_wdata_in;
    logic [3:0]  mem_wmask_in;
    logic        exu_ready, mem_req, reg_wen, ifu_valid, err;
    logic [31:0] mem_addr, mem_wdata, reg_wdata, retire_cnt;
    logic [3:0]  mem_wmask;
    logic [4:0]  reg_waddr;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    bit exp_err = 0;

    always #5 clk = ~clk;

    ysyx_23060187_wbu #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .exu_wbu_valid_i          (valid),
        .wbu_exu_ready_o          (exu_ready),
        .exu_wbu_register_wen_i   (reg_wen_in),
        .exu_wbu_register_waddr_i (reg_waddr_in),
        .exu_wbu_register_wdata_i (reg_wdata_in),
        .exu_wbu_memory_wen_i     (mem_wen_in),
        .exu_wbu_memory_waddr_i   (mem_waddr_in),
        .exu_wbu_memory_wdata_i   (mem_wdata_in),
        .exu_wbu_memory_wmask_i   (mem_wmask_in),
        .wbu_mem_req_o            (mem_req),
        .wbu_mem_addr_o           (mem_addr),
        .wbu_mem_wdata_o          (mem_wdata),
        .wbu_mem_wmask_o          (mem_wmask),
        .mem_wbu_ack_i            (ack),
        .wbu_reg_wen_o            (reg_wen),
        .wbu_reg_waddr_o          (reg_waddr),
        .wbu_reg_wdata_o          (reg_wdata),
        .wbu_ifu_valid_o          (ifu_valid),
        .ifu_wbu_ready_i          (ifu_ready),
        .wbu_error_o              (err),
        .wbu_retire_cnt_o         (retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_inputs();
        reg_wen_in   = 1'($urandom());
        reg_waddr_in = $urandom();
        reg_wdata_in = $urandom();
        mem_wen_in   = 1'($urandom());
        mem_waddr_in = $urandom();
        mem_wdata_in = $urandom();
        mem_wmask_in = 4'($urandom());
    endtask

    // ack_dly: MEM_WAIT cycle index (0-based) in which ack is raised; -1 = never.
    task automatic run_txn(input bit st, input int ack_dly, input int stall,
                           input bit rwen, input logic [31:0] rwa, input logic [31:0] rwd,
                           input logic [31:0] ma, input logic [31:0] md, input logic [3:0] mm);
        bit timed_out, exp_wen, done;
        int exp_req, cyc, req_n, wen_n, ifv_n, rdy_n, first_v, wen_cyc, bad_stab, mc;
        logic [4:0]  got_wa;
        logic [31:0] got_wd;
        timed_out = st && !(ack_dly >= 0 && ack_dly < int'(TO));
        exp_req   = !st ? 0 : (timed_out ? int'(TO) : ack_dly + 1);
        exp_wen   = !timed_out && rwen && (rwa[4:0] != 5'd0);
        chk("idle_ready", 32'(exu_ready), 32'd1);
        valid = 1'b1; reg_wen_in = rwen; reg_waddr_in = rwa; reg_wdata_in = rwd;
        mem_wen_in = st; mem_waddr_in = ma; mem_wdata_in = md; mem_wmask_in = mm;
        @(posedge clk);
        cyc = 0; req_n = 0; wen_n = 0; ifv_n = 0; rdy_n = 0; first_v = -1; wen_cyc = -1;
        bad_stab = 0; mc = 0; done = 0; got_wa = '0; got_wd = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== ma || mem_wdata !== md || mem_wmask !== mm) bad_stab++;
            end
            if (reg_wen) begin
                wen_n++; wen_cyc = cyc; got_wa = reg_waddr; got_wd = reg_wdata;
            end
            if (exu_ready) rdy_n++;
            // Stray acks and IFU readies outside their states must be ignored.
            ack       = mem_req ? (mc == ack_dly) : 1'($urandom());
            if (mem_req) mc++;
            ifu_ready = 1'($urandom());
            scramble_inputs();
            if (ifu_valid) begin
                if (first_v < 0) first_v = cyc;
                ifv_n++;
                ifu_ready = (ifv_n > stall);
                if (ifu_ready) begin
                    valid = 1'b0; ack = 1'b0; done = 1'b1;
                end
            end
        end
        chk("txn_completed", 32'(done), 32'd1);
        exp_cnt++;
        exp_err = exp_err | timed_out;
        chk("req_cycles", req_n, exp_req);
        chk("addr_stable", bad_stab, 0);
        chk("reg_wen_pulses", wen_n, 32'(exp_wen));
        if (exp_wen) begin
            chk("reg_waddr", 32'(got_wa), 32'(rwa[4:0]));
            chk("reg_wdata", got_wd, rwd);
            chk("reg_wen_timing", wen_cyc, first_v - 1);
        end
        chk("ifu_valid_first", first_v, !st ? 2 : (timed_out ? exp_req + 1 : exp_req + 2));
        chk("ifu_valid_held", ifv_n, stall + 1);
        chk("exu_ready_busy", rdy_n, 0);
        @(negedge clk);
        ack = 1'b0; ifu_ready = 1'b0;
        chk("back_to_idle", 32'(exu_ready), 32'd1);
        chk("ifu_valid_low", 32'(ifu_valid), 32'd0);
        chk("retire_cnt", retire_cnt, 32'(exp_cnt));
        chk("error_flag", 32'(err), 32'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; ack = 1'b0; ifu_ready = 1'b0;
        scramble_inputs();
        #1;
        chk("rst_exu_ready", 32'(exu_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_reg_wen", 32'(reg_wen), 32'd0);
        chk("rst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("rst_error", 32'(err), 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_reg_wdata", reg_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_txn(0, -1, 0, 1, 32'd5, 32'hDEADBEEF, 32'h0, 32'h0, 4'h0);
        run_txn(0, -1, 0, 1, 32'd0, 32'hCAFEF00D, 32'h0, 32'h0, 4'h0);
        run_txn(1, 3, 0, 0, 32'd7, 32'h1, 32'h80000010, 32'h12345678, 4'b0011);
        run_txn(1, 0, 0, 1, 32'd9, 32'h55AA55AA, 32'h80000020, 32'hA5A5A5A5, 4'b1111);
        run_txn(1, -1, 0, 1, 32'd3, 32'h77777777, 32'h80000030, 32'h0BADF00D, 4'b0100);
        run_txn(0, -1, 5, 1, 32'd31, 32'h13579BDF, 32'h0, 32'h0, 4'h0);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] rwa;
            rwa = $urandom();
            if ($urandom_range(0, 3) == 0) rwa[4:0] = 5'd0;
            run_txn(1'($urandom()), int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 3)),
                    1'($urandom()), rwa, $urandom(), $urandom(), $urandom(), 4'($urandom()));
        end

        // Reset in the middle of a store that never gets acked.
        chk("pre_rst_error", 32'(err), 32'd1);
        valid = 1'b1; mem_wen_in = 1'b1; reg_wen_in = 1'b1; reg_waddr_in = 32'd4;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_error", 32'(err), 32'd0);
        chk("mid_rst_retire", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0; exp_err = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(exu_ready), 32'd1);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        run_txn(0, -1, 1, 1, 32'd12, 32'h0F0F0F0F, 32'h0, 32'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_wbu.md
# ysyx_23060187_wbu

Write-back unit of the multi-cycle NPC core, sitting downstream of the execute stage on the EXU→WBU valid/ready interface. It accepts one executed instruction and, for stores, issues a single memory write request and waits for acknowledgement. It then commits the register-file write and hands a retire token to the fetch stage. It owns the WBU side of the handshake (WBU_EXU_ready) and bounds every memory write with a timeout.

## Interface
- TIMEOUT_CYCLES, 255, max MEM_WAIT cycles before the store is abandoned (≥1)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- EXU_WBU_valid  in  1  EXU holds a valid instruction
- WBU_EXU_ready  out  1  WBU can accept (high only in IDLE)
- EXU_WBU_register_wen  in  1  instruction writes rd
- EXU_WBU_register_waddr  in  32  rd index; only [4:0] used
- EXU_WBU_register_wdata  in  32  rd data
- EXU_WBU_memory_wen  in  1  instruction is a store
- EXU_WBU_memory_waddr  in  32  store byte address
- EXU_WBU_memory_wdata  in  32  store data
- EXU_WBU_memory_wmask  in  4  byte-lane strobe
- WBU_MEM_req  out  1  write request, held until ack
- WBU_MEM_addr / WBU_MEM_wdata  out  32 each  captured address / data
- WBU_MEM_wmask  out  4  captured strobe
- MEM_WBU_ack  in  1  memory accepted write (sampled in MEM_WAIT only)
- WBU_REG_wen  out  1  register-file write strobe
- WBU_REG_waddr  out  5  register index
- WBU_REG_wdata  out  32  register data
- WBU_IFU_valid  out  1  instruction retired; fetch may advance
- IFU_WBU_ready  in  1  IFU accepts retire token
- WBU_error  out  1  sticky store-timeout flag
- WBU_retire_cnt  out  32  retired-instruction count

## Operation
- States: IDLE, MEM_WAIT, REG_WRITE, DONE. All outputs are Moore, decoded from state and capture registers.
- IDLE:
  - WBU_EXU_ready=1.
  - On EXU_WBU_valid&&WBU_EXU_ready, capture all EXU_WBU_* inputs.
  - Go to MEM_WAIT if memory_wen, else REG_WRITE.
  - Inputs are not sampled in any other state.
- MEM_WAIT:
  - WBU_MEM_req=1; addr/wdata/wmask come from the capture registers and stay stable.
  - Timeout counter cleared on entry, +1 per cycle without ack.
  - MEM_WBU_ack=1 → REG_WRITE, req drops the next cycle.
  - Counter reaching TIMEOUT_CYCLES with no ack: set WBU_error, drop req, suppress the register write, go to DONE.
- REG_WRITE:
  - Lasts exactly one cycle.
  - WBU_REG_wen=1 iff captured register_wen && waddr[4:0]≠0 (x0 writes discarded).
  - WBU_REG_waddr/wdata are driven from the capture registers in every state; they are only meaningful when wen=1.
  - Next state DONE.
- DONE:
  - WBU_IFU_valid=1 until IFU_WBU_ready=1 in the same cycle.
  - On that cycle WBU_retire_cnt increments (wraps 0xFFFFFFFF→0) and the state returns to IDLE.
  - Timed-out stores also retire and count.
- WBU_error: set only by timeout; cleared only by reset.
- MEM_WBU_ack outside MEM_WAIT is ignored.

## Timing
- Reset (async assert, any state): state=IDLE, capture regs=0, counter=0, WBU_error=0, WBU_retire_cnt=0, WBU_MEM_req=0, WBU_REG_wen=0, WBU_IFU_valid=0, WBU_MEM_addr/wdata/wmask=0, WBU_REG_waddr/wdata=0.
- WBU_EXU_ready=1 during and after reset, since it is decoded from IDLE. Reset mid-store drops req immediately, with no ack wait.
- Non-store, handshake at edge 0: REG_WRITE in cycle 1, DONE in cycle 2, IDLE in cycle 3 if IFU ready. Minimum throughput is one instruction per 3 cycles.
- Store with ack in the first MEM_WAIT cycle: MEM_WAIT c1, REG_WRITE c2, DONE c3, IDLE c4.
- Each cycle of ack delay adds one cycle.
- Timeout: req high for exactly TIMEOUT_CYCLES cycles, then DONE the next cycle.
- Ack in the same cycle the counter hits the limit: ack wins, no error.
- IFU back-pressure holds DONE indefinitely; WBU_EXU_ready stays 0.

## Structure
- Shared package ysyx_23060187_pkg holds:
  - state encoding constants (WBU_IDLE=2'd0, WBU_MEM_WAIT=2'd1, WBU_REG_WRITE=2'd2, WBU_DONE=2'd3);
  - register-index width constant (5).
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).
- One sub-module is natural: ysyx_23060187_timeout_cnt, with clear, enable, limit-reached output and parameterised limit.

## Test plan
- ALU result: valid with rd=5, wdata=0xDEADBEEF, no store → WBU_REG_wen=1 one cycle later with waddr=5 / wdata=0xDEADBEEF; WBU_IFU_valid the cycle after; retire_cnt=1.
- Write to x0: rd=0, wen=1 → WBU_REG_wen never asserts; instruction still retires.
- Store, ack delayed 3 cycles: addr=0x80000010, wdata=0x12345678, wmask=4'b0011 → req high 4 cycles with stable addr/data/mask; no reg write; WBU_IFU_valid 2 cycles after ack.
- Store timeout with TIMEOUT_CYCLES=4 and ack never asserted → req high exactly 4 cycles; WBU_error=1 and stays 1; retire still occurs.
- IFU back-pressure: IFU_WBU_ready low 5 cycles in DONE → WBU_IFU_valid held, WBU_EXU_ready=0; new EXU data is ignored until IDLE.
- Reset asserted in MEM_WAIT → req=0 and WBU_error=0 immediately, retire_cnt=0, WBU_EXU_ready=1 after release.
